// File: rtl/pmod_als_spi_rx.sv
// Free-running SPI master for the PmodALS light sensor (ADC081S021).
// Generates cs/sck, shifts in 16-bit frames and holds the last complete frame on value.
module pmod_als_spi_rx #(
  parameter int DIV = 4,
  parameter int GAP = 8
) (
  input  logic        clock,
  input  logic        reset,
  output logic        cs,
  output logic        sck,
  input  logic        sdo,
  output logic [15:0] value
);

  // state    | meaning
  // ST_GAP   | cs high, sck high, idle between frames
  // ST_LEAD  | cs low, sck high, setup before the first sck fall
  // ST_SHIFT | cs low, sck toggling, one bit sampled per sck rise
  typedef enum logic [1:0] {ST_GAP, ST_LEAD, ST_SHIFT} state_t;

  localparam int GAP_CLKS = 2 * GAP * DIV;
  localparam int CW       = $clog2(GAP_CLKS + 1);
  localparam logic [CW-1:0] GAP_TC = CW'(GAP_CLKS - 1);
  localparam logic [CW-1:0] DIV_TC = CW'(DIV - 1);

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    bit_cnt, bit_d;
  logic [15:0]   shift, shift_d;
  logic [15:0]   value_d;
  logic          cs_d, sck_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_GAP;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      value   <= '0;
      cs      <= 1'b1;
      sck     <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_cnt <= bit_d;
      shift   <= shift_d;
      value   <= value_d;
      cs      <= cs_d;
      sck     <= sck_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    bit_d   = bit_cnt;
    shift_d = shift;
    value_d = value;
    cs_d    = cs;
    sck_d   = sck;
    unique case (state)
      ST_GAP: begin
        if (cnt == GAP_TC) begin
          state_d = ST_LEAD;
          cnt_d   = '0;
          cs_d    = 1'b0;
        end
      end
      ST_LEAD: begin
        if (cnt == DIV_TC) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          sck_d   = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (cnt == DIV_TC) begin
          cnt_d = '0;
          if (!sck) begin
            // sample on the edge that drives sck high; the last sample completes the frame
            sck_d   = 1'b1;
            shift_d = {shift[14:0], sdo};
            if (bit_cnt == 4'd15) value_d = {shift[14:0], sdo};
          end else if (bit_cnt == 4'd15) begin
            state_d = ST_GAP;
            cs_d    = 1'b1;
            bit_d   = '0;
          end else begin
            sck_d = 1'b0;
            bit_d = bit_cnt + 1'b1;
          end
        end
      end
      default: state_d = ST_GAP;
    endcase
  end

endmodule

// File: tb/tb_pmod_als_spi_rx.sv
// Scoreboard bench for pmod_als_spi_rx: directed frames, mid-frame reset,
// random soak at default parameters and a DIV=2/GAP=1 instance.
module tb_pmod_als_spi_rx;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cs, sck, cs2, sck2;
  logic        sdo = 1'b0, sdo2 = 1'b0;
  logic [15:0] value, value2;

  always #5 clock = ~clock;

  pmod_als_spi_rx dut (
    .clock(clock), .reset(reset), .cs(cs), .sck(sck), .sdo(sdo), .value(value)
  );

  pmod_als_spi_rx #(.DIV(2), .GAP(1)) dut2 (
    .clock(clock), .reset(reset), .cs(cs2), .sck(sck2), .sdo(sdo2), .value(value2)
  );

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp2_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Directed frames; index 2 is cut short by a reset.
  localparam int NDIR = 6;
  logic [15:0] dir_pat [NDIR] = '{16'h1660, 16'hFFFF, 16'hA5C3, 16'hFFFF, 16'h0000, 16'h5A3C};

  logic        d_pcs = 1'b1, d_psck = 1'b1, rnd_mode = 1'b0;
  logic        d2_pcs = 1'b1, d2_psck = 1'b1;
  logic [15:0] pat, samp, samp2;
  int          frame_no = 0, idx = 0, nsamp = 0, drv_rise = 0, n2 = 0;

  // One clock of stimulus, applied on the falling edge.
  task automatic tick();
    @(negedge clock);
    if (d_pcs && !cs) begin
      if (frame_no < NDIR) begin
        rnd_mode = 1'b0;
        pat = dir_pat[frame_no];
        exp_q.push_back(pat);
      end else begin
        rnd_mode = 1'b1;
      end
      frame_no++;
      idx = 15;
      nsamp = 0;
      drv_rise = 0;
    end
    if (!cs && !d_psck && sck) begin
      drv_rise++;
      if (rnd_mode) begin
        samp = {samp[14:0], sdo};
        nsamp++;
        if (nsamp == 16) exp_q.push_back(samp);
      end
    end
    if (rnd_mode) sdo = 1'($urandom);
    else if (!cs && d_psck && !sck && idx >= 0) begin
      sdo = pat[idx];
      idx--;
    end
    d_pcs = cs;
    d_psck = sck;

    if (d2_pcs && !cs2) n2 = 0;
    if (!cs2 && !d2_psck && sck2) begin
      samp2 = {samp2[14:0], sdo2};
      n2++;
      if (n2 == 16) exp2_q.push_back(samp2);
    end
    sdo2 = 1'($urandom);
    d2_pcs = cs2;
    d2_psck = sck2;
  endtask

  task automatic release_check();
    int n;
    n = 0;
    reset = 1'b0;
    do begin
      tick();
      n++;
    end while (cs && n < 200);
    chk("first_cs_fall_clks", n, 64);
  endtask

  // Monitor for the default-parameter instance.
  int          rise_n = 0, fall_n = 0, low_len = 0, high_len = 0, half_len = 0, half_bad = 0;
  int          bad_change = 0, gap_edges = 0, frames_done = 0;
  logic        m_pcs = 1'b1, m_psck = 1'b1, skip_high = 1'b1, at16 = 1'b0;
  logic [15:0] last_v = '0, e;

  always begin
    @(negedge clock);
    #2;
    if (reset) begin
      rise_n = 0; fall_n = 0; low_len = 0; high_len = 0; half_len = 0; half_bad = 0;
      m_pcs = 1'b1; m_psck = 1'b1; skip_high = 1'b1; last_v = value;
    end else begin
      at16 = 1'b0;
      half_len++;
      if (m_pcs && !cs) begin
        if (!skip_high) chk("cs_high_clks", high_len, 64);
        skip_high = 1'b0;
        low_len = 0; fall_n = 0; rise_n = 0; half_bad = 0; half_len = 0;
      end
      if (!m_pcs && cs) begin
        if (half_len != 4) half_bad++;
        chk("sck_falls", fall_n, 16);
        chk("cs_low_clks", low_len, 132);
        chk("sck_half_bad", half_bad, 0);
        high_len = 0;
      end
      if (!cs && sck != m_psck) begin
        if (half_len != 4) half_bad++;
        half_len = 0;
        if (sck) begin
          rise_n++;
          if (rise_n == 16) begin
            at16 = 1'b1;
            frames_done++;
            if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
            else begin
              e = exp_q.pop_front();
              chk("value", value, e);
            end
          end
        end else begin
          fall_n++;
        end
      end
      if (cs && m_pcs && sck != m_psck) gap_edges++;
      if (value != last_v && !at16) bad_change++;
      if (cs) high_len++; else low_len++;
      last_v = value; m_pcs = cs; m_psck = sck;
    end
  end

  // Monitor for the DIV=2, GAP=1 instance.
  int          r2 = 0, f2 = 0, low2 = 0, high2 = 0, half2 = 0, hbad2 = 0, frames2 = 0;
  logic        m2_pcs = 1'b1, m2_psck = 1'b1, skip2 = 1'b1;
  logic [15:0] e2;

  always begin
    @(negedge clock);
    #2;
    if (reset) begin
      r2 = 0; f2 = 0; low2 = 0; high2 = 0; half2 = 0; hbad2 = 0;
      m2_pcs = 1'b1; m2_psck = 1'b1; skip2 = 1'b1;
    end else begin
      half2++;
      if (m2_pcs && !cs2) begin
        if (!skip2) chk("dut2_cs_high_clks", high2, 4);
        skip2 = 1'b0;
        low2 = 0; f2 = 0; r2 = 0; hbad2 = 0; half2 = 0;
      end
      if (!m2_pcs && cs2) begin
        if (half2 != 2) hbad2++;
        chk("dut2_sck_falls", f2, 16);
        chk("dut2_cs_low_clks", low2, 66);
        chk("dut2_sck_half_bad", hbad2, 0);
        high2 = 0;
      end
      if (!cs2 && sck2 != m2_psck) begin
        if (half2 != 2) hbad2++;
        half2 = 0;
        if (sck2) begin
          r2++;
          if (r2 == 16) begin
            frames2++;
            if (exp2_q.size() == 0) chk("dut2_scoreboard_empty", 1, 0);
            else begin
              e2 = exp2_q.pop_front();
              chk("dut2_value", value2, e2);
            end
          end
        end else begin
          f2++;
        end
      end
      if (cs2) high2++; else low2++;
      m2_pcs = cs2; m2_psck = sck2;
    end
  end

  initial begin
    int b;
    #1 reset = 1'b1;
    #1;
    chk("reset_cs", cs, 1);
    chk("reset_sck", sck, 1);
    chk("reset_value", value, 0);
    repeat (3) tick();
    release_check();

    b = 0;
    while (!(frame_no == 3 && drv_rise >= 5) && b < 2000) begin
      tick();
      b++;
    end
    chk("reach_mid_frame", b < 2000, 1);
    chk("value_before_reset", value, 16'hFFFF);
    chk("cs_low_mid_frame", cs, 0);
    #3 reset = 1'b1;
    exp_q.delete();
    exp2_q.delete();
    #1;
    chk("mid_reset_cs", cs, 1);
    chk("mid_reset_sck", sck, 1);
    chk("mid_reset_value", value, 0);
    chk("mid_reset_value2", value2, 0);
    repeat (5) tick();
    release_check();

    b = 0;
    while (frame_no < NDIR + 11 && b < 6000) begin
      tick();
      b++;
    end
    chk("reach_end", b < 6000, 1);
    repeat (4) tick();
    chk("frames_done", frames_done, 15);
    chk("dut2_frames_min", frames2 >= 20, 1);
    chk("value_unexpected_changes", bad_change, 0);
    chk("sck_edges_while_cs_high", gap_edges, 0);
    chk("scoreboard_leftover", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
